// File: rtl/scroll_banner.sv
// ============================================================================
// Module   : scroll_banner
// Brief    : Scrolling multi-digit message display with wrap and bounce modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module scroll_banner #(
    parameter int MSG_LEN  = 12,
    parameter int DIGITS   = 3,
    parameter int CODE_W   = 5,
    parameter int ADDR_W   = 4,
    parameter int TICK_DIV = 12000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pause,
    input  logic                     dirn,
    input  logic                     bounce,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [CODE_W-1:0]        wr_data,
    output logic [DIGITS*CODE_W-1:0] hex,
    output logic [ADDR_W-1:0]        pos,
    output logic                     turn
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HEX_W = DIGITS * CODE_W;

    localparam logic [PRE_W-1:0]  PRE_TOP  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] LAST_POS = ADDR_W'(MSG_LEN - 1);
    localparam logic [ADDR_W-1:0] MAXP     = ADDR_W'(MSG_LEN - DIGITS);
    // One extra bit so MSG_LEN == 2**ADDR_W is representable
    localparam logic [ADDR_W:0]   LEN_EXT  = (ADDR_W + 1)'(MSG_LEN);

    function automatic logic [HEX_W-1:0] hex_reset_value();
        logic [HEX_W-1:0] v;
        v = '0;
        for (int k = 0; k < DIGITS; k++) begin
            v[k*CODE_W +: CODE_W] = CODE_W'(k);
        end
        return v;
    endfunction

    localparam logic [HEX_W-1:0] HEX_RST = hex_reset_value();

    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [ADDR_W-1:0] pos_q, pos_d;
    logic              up_q, up_d;
    logic              turn_q, turn_d;
    logic [HEX_W-1:0]  hex_q, hex_d;
    logic [CODE_W-1:0] msg_q [MSG_LEN];

    logic step;
    logic wr_ok;

    assign step  = !pause && (presc_q == PRE_TOP);
    assign wr_ok = wr_en && ({1'b0, wr_addr} < LEN_EXT);

    always_comb begin
        presc_d = presc_q;
        if (!pause) begin
            presc_d = (presc_q == PRE_TOP) ? '0 : presc_q + 1'b1;
        end
    end

    always_comb begin
        pos_d  = pos_q;
        up_d   = up_q;
        turn_d = 1'b0;
        if (step) begin
            if (!bounce) begin
                if (dirn) begin
                    if (pos_q == LAST_POS) begin
                        pos_d  = '0;
                        turn_d = 1'b1;
                    end else begin
                        pos_d = pos_q + 1'b1;
                    end
                end else begin
                    if (pos_q == '0) begin
                        pos_d  = LAST_POS;
                        turn_d = 1'b1;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end else if (up_q) begin
                // pos may sit above MAXP after a mode switch; reverse from there
                if (pos_q < MAXP) begin
                    pos_d = pos_q + 1'b1;
                end else begin
                    up_d   = 1'b0;
                    pos_d  = pos_q - 1'b1;
                    turn_d = 1'b1;
                end
            end else begin
                if (pos_q != '0) begin
                    pos_d = pos_q - 1'b1;
                end else begin
                    up_d   = 1'b1;
                    pos_d  = ADDR_W'(1);
                    turn_d = 1'b1;
                end
            end
        end
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        logic [ADDR_W:0]   sum;
        logic [ADDR_W-1:0] idx;

        assign sum = {1'b0, pos_q} + (ADDR_W + 1)'(k);
        assign idx = (sum >= LEN_EXT) ? ADDR_W'(sum - LEN_EXT) : ADDR_W'(sum);
        assign hex_d[k*CODE_W +: CODE_W] = msg_q[idx];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            pos_q   <= '0;
            up_q    <= 1'b1;
            turn_q  <= 1'b0;
            hex_q   <= HEX_RST;
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= CODE_W'(i);
            end
        end else begin
            presc_q <= presc_d;
            pos_q   <= pos_d;
            up_q    <= up_d;
            turn_q  <= turn_d;
            hex_q   <= hex_d;
            if (wr_ok) begin
                msg_q[wr_addr] <= wr_data;
            end
        end
    end

    assign hex  = hex_q;
    assign pos  = pos_q;
    assign turn = turn_q;

endmodule

`default_nettype wire

// File: tb/tb_scroll_banner.sv
// ============================================================================
// Module   : tb_scroll_banner
// Brief    : Table-driven, scoreboard-checked bench for scroll_banner.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_scroll_banner;

    localparam int MSG_LEN  = 12;
    localparam int DIGITS   = 3;
    localparam int CODE_W   = 5;
    localparam int ADDR_W   = 4;
    localparam int TICK_DIV = 4;
    localparam int HW       = DIGITS * CODE_W;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              pause   = 1'b0;
    logic              dirn    = 1'b1;
    logic              bounce  = 1'b0;
    logic              wr_en   = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [CODE_W-1:0] wr_data = '0;
    logic [HW-1:0]     hex;
    logic [ADDR_W-1:0] pos;
    logic              turn;

    int checks = 0;
    int errors = 0;

    scroll_banner #(
        .MSG_LEN (MSG_LEN),
        .DIGITS  (DIGITS),
        .CODE_W  (CODE_W),
        .ADDR_W  (ADDR_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pause  (pause),
        .dirn   (dirn),
        .bounce (bounce),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .hex    (hex),
        .pos    (pos),
        .turn   (turn)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] pos;
        logic              turn;
        logic [HW-1:0]     hex;
    } exp_t;

    typedef struct {
        string       name;
        bit          rst;
        bit          p;
        bit          d;
        bit          b;
        bit          we;
        logic [3:0]  addr;
        logic [4:0]  data;
        int          cycles;
        int          exp_pos;
        int          exp_turns;
        bit          chk_hex;
        logic [14:0] exp_hex;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[$];

    int            m_pre;
    int            m_pos;
    bit            m_up;
    bit            m_turn;
    int            m_msg[MSG_LEN];
    logic [HW-1:0] m_hex;

    function automatic void model_reset();
        m_pre  = 0;
        m_pos  = 0;
        m_up   = 1'b1;
        m_turn = 1'b0;
        for (int i = 0; i < MSG_LEN; i++) m_msg[i] = i % 32;
        for (int k = 0; k < DIGITS; k++) m_hex[k*CODE_W +: CODE_W] = CODE_W'(k);
    endfunction

    // Advance the reference model across one rising edge with the given inputs
    function automatic void model_edge(input bit p, input bit d, input bit b,
                                       input bit we, input int addr, input int data);
        logic [HW-1:0] nh;
        bit            stp;
        int            np;
        for (int k = 0; k < DIGITS; k++) nh[k*CODE_W +: CODE_W] = CODE_W'(m_msg[(m_pos + k) % MSG_LEN]);
        stp = !p && (m_pre == TICK_DIV - 1);
        if (!p) m_pre = (m_pre + 1) % TICK_DIV;
        m_turn = 1'b0;
        np     = m_pos;
        if (stp) begin
            if (!b) begin
                np     = d ? (m_pos + 1) % MSG_LEN : (m_pos + MSG_LEN - 1) % MSG_LEN;
                m_turn = (d && m_pos == MSG_LEN - 1) || (!d && m_pos == 0);
            end else if (m_up) begin
                if (m_pos < MSG_LEN - DIGITS) np = m_pos + 1;
                else begin m_up = 1'b0; np = m_pos - 1; m_turn = 1'b1; end
            end else begin
                if (m_pos > 0) np = m_pos - 1;
                else begin m_up = 1'b1; np = 1; m_turn = 1'b1; end
            end
        end
        m_pos = np;
        if (we && addr < MSG_LEN) m_msg[addr] = data;
        m_hex = nh;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_cycle(input bit p, input bit d, input bit b, input bit we,
                             input logic [3:0] a, input logic [4:0] dt, inout int nturn);
        exp_t e;
        pause   = p;
        dirn    = d;
        bounce  = b;
        wr_en   = we;
        wr_addr = a;
        wr_data = dt;
        model_edge(p, d, b, we, int'(a), int'(dt));
        e.pos  = ADDR_W'(m_pos);
        e.turn = m_turn;
        e.hex  = m_hex;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        checks++;
        if (pos !== e.pos || turn !== e.turn || hex !== e.hex) begin
            errors++;
            $display("FAIL cycle t=%0t pos=%0d req %0d turn=%0b req %0b hex=%h req %h",
                     $time, pos, e.pos, turn, e.turn, hex, e.hex);
        end
        if (turn === 1'b1) nturn++;
    endtask

    // Asserts reset between edges, checks the asynchronous effect, and holds
    // a write strobe across one edge under reset to prove it is discarded.
    task automatic do_reset();
        #2;
        reset   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = '0;
        wr_data = 5'h1E;
        model_reset();
        #1;
        chk("reset_pos", 32'(pos), 32'd0);
        chk("reset_turn", 32'(turn), 32'd0);
        chk("reset_hex", 32'(hex), 32'({5'd2, 5'd1, 5'd0}));
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        reset = 1'b1;
    endtask

    task automatic add(input string n, input bit r, input bit p, input bit d, input bit b,
                       input bit we, input logic [3:0] a, input logic [4:0] dt, input int cyc,
                       input int ep, input int et, input bit ch, input logic [14:0] eh);
        vec_t v;
        v = '{n, r, p, d, b, we, a, dt, cyc, ep, et, ch, eh};
        vecs.push_back(v);
    endtask

    initial begin
        //   name                rst p  d  b  we addr   data   cyc pos turns hex?  hex
        add("wrap_first_step",   1, 0, 1, 0, 0, 4'd0,  5'd0,   4,  1, 0, 0, 15'd0);
        add("wrap_hex",          0, 0, 1, 0, 0, 4'd0,  5'd0,   1,  1, 0, 1, {5'd3, 5'd2, 5'd1});
        add("wrap_full_cycle",   0, 0, 1, 0, 0, 4'd0,  5'd0,  43,  0, 1, 1, {5'd1, 5'd0, 5'd11});
        add("dec_first_step",    1, 0, 0, 0, 0, 4'd0,  5'd0,   4, 11, 1, 0, 15'd0);
        add("dec_hex",           0, 0, 0, 0, 0, 4'd0,  5'd0,   1, 11, 0, 1, {5'd1, 5'd0, 5'd11});
        add("bounce_up",         1, 0, 1, 1, 0, 4'd0,  5'd0,  36,  9, 0, 0, 15'd0);
        add("bounce_top_turn",   0, 0, 1, 1, 0, 4'd0,  5'd0,   4,  8, 1, 0, 15'd0);
        add("bounce_down",       0, 0, 1, 1, 0, 4'd0,  5'd0,  32,  0, 0, 0, 15'd0);
        add("bounce_bot_turn",   0, 0, 1, 1, 0, 4'd0,  5'd0,   4,  1, 1, 0, 15'd0);
        add("pre_pause",         1, 0, 1, 0, 0, 4'd0,  5'd0,   2,  0, 0, 0, 15'd0);
        add("paused",            0, 1, 1, 0, 0, 4'd0,  5'd0,  10,  0, 0, 0, 15'd0);
        add("pause_release",     0, 0, 1, 0, 0, 4'd0,  5'd0,   1,  0, 0, 0, 15'd0);
        add("step_after_pause",  0, 0, 1, 0, 0, 4'd0,  5'd0,   1,  1, 0, 0, 15'd0);
        add("pre_write",         1, 0, 1, 0, 0, 4'd0,  5'd0,   3,  0, 0, 0, 15'd0);
        add("write_and_step",    0, 0, 1, 0, 1, 4'd1,  5'h1F,  1,  1, 0, 0, 15'd0);
        add("write_hex",         0, 0, 1, 0, 0, 4'd0,  5'd0,   1,  1, 0, 1, {5'd3, 5'd2, 5'h1F});
        add("write_oob",         0, 0, 1, 0, 1, 4'd12, 5'h1F,  1,  1, 0, 1, {5'd3, 5'd2, 5'h1F});
        add("oob_sweep",         0, 0, 1, 0, 0, 4'd0,  5'd0,  47,  1, 1, 0, 15'd0);
        add("to_eleven",         1, 0, 1, 0, 0, 4'd0,  5'd0,  44, 11, 0, 0, 15'd0);
        add("bounce_switch",     0, 0, 1, 1, 0, 4'd0,  5'd0,   4, 10, 1, 0, 15'd0);
        add("bounce_descend",    0, 0, 1, 1, 0, 4'd0,  5'd0,  10,  8, 0, 0, 15'd0);
        add("post_reset_hold",   1, 0, 1, 0, 0, 4'd0,  5'd0,   3,  0, 0, 1, {5'd2, 5'd1, 5'd0});
        add("post_reset_step",   0, 0, 1, 0, 0, 4'd0,  5'd0,   1,  1, 0, 0, 15'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            int nt;
            nt = 0;
            if (vecs[i].rst) do_reset();
            for (int c = 0; c < vecs[i].cycles; c++) begin
                run_cycle(vecs[i].p, vecs[i].d, vecs[i].b, vecs[i].we,
                          vecs[i].addr, vecs[i].data, nt);
            end
            chk({vecs[i].name, "_pos"}, 32'(pos), 32'(vecs[i].exp_pos));
            chk({vecs[i].name, "_turns"}, 32'(nt), 32'(vecs[i].exp_turns));
            if (vecs[i].chk_hex) chk({vecs[i].name, "_hex"}, 32'(hex), 32'(vecs[i].exp_hex));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
